// File: rtl/design_ctrl_pkg.sv
// Shared register map, field positions and reset values for the design_ctrl block.
package design_ctrl_pkg;

    localparam logic [3:0] CTRL_OFF   = 4'h0;
    localparam logic [3:0] CLKDIV_OFF = 4'h4;
    localparam logic [3:0] RSTLEN_OFF = 4'h8;
    localparam logic [3:0] STATUS_OFF = 4'hC;

    localparam int SEL_LSB        = 0;
    localparam int SEL_W          = 4;
    localparam int SOFT_RST_BIT   = 8;
    localparam int CLK_EN_BIT     = 16;
    localparam int RST_BUSY_BIT   = 0;
    localparam int STATUS_SEL_LSB = 4;
    localparam int ECNT_LSB       = 16;

    localparam logic [7:0]  LEN_RST  = 8'd3;
    localparam logic [15:0] DIV_RST  = 16'd0;
    localparam logic [8:0]  RCNT_RST = 9'd4;

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_CLKDIV = 3'd1,
        REG_RSTLEN = 3'd2,
        REG_STATUS = 3'd3,
        REG_NONE   = 3'd4
    } reg_e;

    // Merge write data into the current value of a register, byte by byte.
    function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = wdat[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = cur[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/design_clk_div.sv
// Programmable divider: toggles the design clock when the counter reaches DIV and
// emits a one-cycle pulse aligned with every 0->1 toggle.
module design_clk_div
    import design_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] div,
    output logic        design_clk_o,
    output logic        rise
);

    logic [15:0] cnt_r;
    logic        clk_r;
    logic        rise_r;

    // Counter, divided clock and rise pulse; >= lets a shrunk DIV take effect at once
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 16'd0;
            clk_r  <= 1'b0;
            rise_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= 16'd0;
            clk_r  <= 1'b0;
            rise_r <= 1'b0;
        end else if (cnt_r >= div) begin
            cnt_r  <= 16'd0;
            clk_r  <= ~clk_r;
            rise_r <= ~clk_r;
        end else begin
            cnt_r  <= cnt_r + 16'd1;
            rise_r <= 1'b0;
        end
    end

    assign design_clk_o = clk_r;
    assign rise         = rise_r;

endmodule

// File: rtl/design_ctrl.sv
// Wishbone register file, project select and per-project reset sequencer.
// Optional rise-event counter in STATUS[31:16] under DESIGN_CTRL_EDGE_COUNTER_EN.
module design_ctrl
    import design_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_DESIGNS = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [3:0]             design_sel_o,
    output logic                   design_clk_o,
    output logic [NUM_DESIGNS-1:0] design_rst_o
);

    logic                   ack_r;
    logic [31:0]            dat_r;
    logic [3:0]             sel_r;
    logic                   clk_en_r;
    logic [15:0]            div_r;
    logic [7:0]             len_r;
    logic                   busy_r;
    logic [8:0]             rcnt_r;
    logic [NUM_DESIGNS-1:0] rst_r;

    logic                   hit_s;
    logic                   acc_s;
    logic                   wr_s;
    logic                   ctrl_wr_s;
    logic                   trig_s;
    logic                   rise_s;
    reg_e                   reg_s;
    logic [31:0]            ctrl_rd_s;
    logic [31:0]            status_rd_s;
    logic [31:0]            rdata_s;
    logic [31:0]            wnew_s;
    logic [15:0]            ecnt_s;
    logic [3:0]             sel_nxt_s;
    logic                   clk_en_nxt_s;
    logic                   busy_nxt_s;
    logic [8:0]             rcnt_nxt_s;
    logic [NUM_DESIGNS-1:0] rst_nxt_s;

    // Address decode, read mux and byte-merged write value
    always_comb begin
        hit_s = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        acc_s = wbs_stb_i & wbs_cyc_i & ~ack_r & hit_s;
        wr_s  = acc_s & wbs_we_i;

        case (wbs_adr_i[3:0])
            CTRL_OFF:   reg_s = REG_CTRL;
            CLKDIV_OFF: reg_s = REG_CLKDIV;
            RSTLEN_OFF: reg_s = REG_RSTLEN;
            STATUS_OFF: reg_s = REG_STATUS;
            default:    reg_s = REG_NONE;
        endcase

        ctrl_rd_s                         = 32'h0;
        ctrl_rd_s[SEL_LSB +: SEL_W]       = sel_r;
        ctrl_rd_s[CLK_EN_BIT]             = clk_en_r;
        status_rd_s                       = 32'h0;
        status_rd_s[RST_BUSY_BIT]         = busy_r;
        status_rd_s[STATUS_SEL_LSB +: 4]  = sel_r;
        status_rd_s[ECNT_LSB +: 16]       = ecnt_s;

        case (reg_s)
            REG_CTRL:   rdata_s = ctrl_rd_s;
            REG_CLKDIV: rdata_s = {16'h0, div_r};
            REG_RSTLEN: rdata_s = {24'h0, len_r};
            REG_STATUS: rdata_s = status_rd_s;
            default:    rdata_s = 32'h0;
        endcase

        wnew_s = apply_be(rdata_s, wbs_dat_i, wbs_sel_i);
    end

    // Next select, clock enable and reset-sequencer state; a trigger beats a rise event
    always_comb begin
        ctrl_wr_s    = wr_s & (reg_s == REG_CTRL);
        sel_nxt_s    = sel_r;
        clk_en_nxt_s = clk_en_r;
        trig_s       = 1'b0;
        busy_nxt_s   = busy_r;
        rcnt_nxt_s   = rcnt_r;
        rst_nxt_s    = '1;

        if (ctrl_wr_s) begin
            sel_nxt_s    = wnew_s[SEL_LSB +: SEL_W];
            clk_en_nxt_s = wnew_s[CLK_EN_BIT];
            trig_s       = (wbs_sel_i[1] & wbs_dat_i[SOFT_RST_BIT]) |
                           (wnew_s[SEL_LSB +: SEL_W] != sel_r);
        end else begin
            sel_nxt_s    = sel_r;
            clk_en_nxt_s = clk_en_r;
        end

        if (trig_s) begin
            busy_nxt_s = 1'b1;
            rcnt_nxt_s = {1'b0, len_r} + 9'd1;
        end else if (busy_r && rise_s) begin
            if (rcnt_r > 9'd1) begin
                busy_nxt_s = 1'b1;
                rcnt_nxt_s = rcnt_r - 9'd1;
            end else begin
                busy_nxt_s = 1'b0;
                rcnt_nxt_s = 9'd0;
            end
        end else begin
            busy_nxt_s = busy_r;
            rcnt_nxt_s = rcnt_r;
        end

        // Built from next-state values so a new SEL is never seen out of reset
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            rst_nxt_s[i] = busy_nxt_s | (int'(sel_nxt_s) != i);
        end
    end

    // Bus handshake, register file and sequencer state
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r    <= 1'b0;
            dat_r    <= 32'h0;
            sel_r    <= 4'h0;
            clk_en_r <= 1'b0;
            div_r    <= DIV_RST;
            len_r    <= LEN_RST;
            busy_r   <= 1'b1;
            rcnt_r   <= RCNT_RST;
            rst_r    <= '1;
        end else begin
            ack_r    <= acc_s;
            sel_r    <= sel_nxt_s;
            clk_en_r <= clk_en_nxt_s;
            busy_r   <= busy_nxt_s;
            rcnt_r   <= rcnt_nxt_s;
            rst_r    <= rst_nxt_s;
            if (acc_s) begin
                dat_r <= rdata_s;
            end else begin
                dat_r <= 32'h0;
            end
            if (wr_s && reg_s == REG_CLKDIV) begin
                div_r <= wnew_s[15:0];
            end
            if (wr_s && reg_s == REG_RSTLEN) begin
                len_r <= wnew_s[7:0];
            end
        end
    end

`ifdef DESIGN_CTRL_EDGE_COUNTER_EN
    logic [15:0] ecnt_r;

    // Rise-event counter, cleared by any reset trigger, wraps naturally
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ecnt_r <= 16'h0;
        end else if (trig_s) begin
            ecnt_r <= 16'h0;
        end else if (rise_s) begin
            ecnt_r <= ecnt_r + 16'd1;
        end
    end

    assign ecnt_s = ecnt_r;
`else
    assign ecnt_s = 16'h0;
`endif

    design_clk_div u_clk_div (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .en           (clk_en_r),
        .div          (div_r),
        .design_clk_o (design_clk_o),
        .rise         (rise_s)
    );

    assign wbs_ack_o    = ack_r;
    assign wbs_dat_o    = dat_r;
    assign design_sel_o = sel_r;
    assign design_rst_o = rst_r;

endmodule
